// File: rtl/motor_pkg.sv
// Shared definitions for the motor channel responders: state encoding,
// default timing constants and a width helper.
package motor_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RAMP      = 3'd1,
        ST_RUN       = 3'd2,
        ST_FAULT     = 3'd3,
        ST_RAMP_DOWN = 3'd4
    } motor_state_e;

    localparam int unsigned PWM_PERIOD_DEF    = 100;
    localparam int unsigned DUTY_MAX_DEF      = 80;
    localparam int unsigned RAMP_STEP_CYC_DEF = 50;
    localparam int unsigned STALL_CYC_DEF     = 1000;
    localparam int unsigned OC_DEBOUNCE_DEF   = 4;

    // ceil(log2(value)); 0 for value <= 1
    function automatic int unsigned clog2_u(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/motor_channel_ctrl_pwm_gen.sv
// Free-running PWM counter with a registered duty compare.
module pwm_gen
    import motor_pkg::*;
#(
    parameter  int unsigned PWM_PERIOD = PWM_PERIOD_DEF,
    localparam int unsigned DUTY_W     = clog2_u(PWM_PERIOD + 1)
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [DUTY_W-1:0] duty,
    input  logic              force_off,
    output logic              pwm
);

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);

    logic [DUTY_W-1:0] pwm_cnt;

    // duty == 0 never matches, duty == PWM_PERIOD always matches
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            pwm_cnt <= '0;
            pwm     <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + DUTY_W'(1);
            pwm     <= !force_off && (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/motor_channel_ctrl.sv
// Per-motor responder: soft-start, stall watchdog, overcurrent debounce, latched fault.
// Build option MOTOR_CHANNEL_SOFTSTOP_EN adds a RAMP_DOWN soft-stop state.
module motor_channel_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned PWM_PERIOD    = PWM_PERIOD_DEF,
    parameter int unsigned DUTY_MAX      = DUTY_MAX_DEF,
    parameter int unsigned RAMP_STEP_CYC = RAMP_STEP_CYC_DEF,
    parameter int unsigned STALL_CYC     = STALL_CYC_DEF,
    parameter int unsigned OC_DEBOUNCE   = OC_DEBOUNCE_DEF
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic ENA,
    input  logic OC_IN,
    input  logic ENC_TICK,
    output logic PWM_OUT,
    output logic ERR,
    output logic RUNNING
);

    localparam int unsigned DUTY_W  = clog2_u(PWM_PERIOD + 1);
    localparam int unsigned STEP_W  = (clog2_u(RAMP_STEP_CYC) > 0) ? clog2_u(RAMP_STEP_CYC) : 1;
    localparam int unsigned STALL_W = (clog2_u(STALL_CYC) > 0) ? clog2_u(STALL_CYC) : 1;
    localparam int unsigned OC_W    = clog2_u(OC_DEBOUNCE + 1);

    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(DUTY_MAX);

    motor_state_e       state, state_d;
    logic [DUTY_W-1:0]  duty, duty_d;
    logic [STEP_W-1:0]  step_cnt, step_cnt_d;
    logic [STALL_W-1:0] stall_cnt, stall_cnt_d;
    logic [OC_W-1:0]    oc_cnt, oc_cnt_d;
    logic               step_done, stall_hit, oc_hit, pwm_off;

    // Each condition fires on the edge at which its counter would reach the limit
    assign step_done = (32'(step_cnt) + 32'd1 >= RAMP_STEP_CYC);
    assign stall_hit = !ENC_TICK && (32'(stall_cnt) + 32'd2 >= STALL_CYC);
    assign oc_hit    = OC_IN && (32'(oc_cnt) + 32'd1 >= OC_DEBOUNCE);
    assign pwm_off   = !(state == ST_RAMP || state == ST_RUN || state == ST_RAMP_DOWN);

    always_comb begin
        state_d     = state;
        duty_d      = duty;
        step_cnt_d  = step_cnt;
        stall_cnt_d = '0;
        oc_cnt_d    = OC_IN ? oc_cnt + OC_W'(1) : '0;
        unique case (state)
            ST_OFF: begin
                oc_cnt_d = '0;
                if (ENA) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (oc_hit) begin
                    state_d = ST_FAULT;
                end else if (!ENA) begin
`ifdef MOTOR_CHANNEL_SOFTSTOP_EN
                    state_d    = ST_RAMP_DOWN;
                    step_cnt_d = '0;
`else
                    state_d = ST_OFF;
`endif
                end else if (duty >= DUTY_FULL) begin
                    state_d = ST_RUN;
                end else if (step_done) begin
                    duty_d     = duty + DUTY_W'(1);
                    step_cnt_d = '0;
                    if (duty + DUTY_W'(1) >= DUTY_FULL) state_d = ST_RUN;
                end else begin
                    step_cnt_d = step_cnt + STEP_W'(1);
                end
            end
            ST_RUN: begin
                duty_d      = DUTY_FULL;
                stall_cnt_d = ENC_TICK ? '0 : stall_cnt + STALL_W'(1);
                if (oc_hit || stall_hit) begin
                    state_d = ST_FAULT;
                end else if (!ENA) begin
`ifdef MOTOR_CHANNEL_SOFTSTOP_EN
                    state_d    = ST_RAMP_DOWN;
                    step_cnt_d = '0;
`else
                    state_d = ST_OFF;
`endif
                end
            end
            ST_FAULT: begin
                if (!ENA) state_d = ST_OFF;
            end
`ifdef MOTOR_CHANNEL_SOFTSTOP_EN
            ST_RAMP_DOWN: begin
                if (oc_hit) begin
                    state_d = ST_FAULT;
                end else if (ENA) begin
                    state_d    = ST_RAMP;
                    step_cnt_d = '0;
                end else if (duty == '0) begin
                    state_d = ST_OFF;
                end else if (step_done) begin
                    duty_d     = duty - DUTY_W'(1);
                    step_cnt_d = '0;
                    if (duty == DUTY_W'(1)) state_d = ST_OFF;
                end else begin
                    step_cnt_d = step_cnt + STEP_W'(1);
                end
            end
`endif
            default: state_d = ST_OFF;
        endcase
        // OFF and FAULT keep the gate idle and every counter cleared
        if (state_d == ST_OFF || state_d == ST_FAULT) begin
            duty_d      = '0;
            step_cnt_d  = '0;
            stall_cnt_d = '0;
            oc_cnt_d    = '0;
        end
    end

    // ERR/RUNNING decode the next state so they switch on the same edge as state
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= ST_OFF;
            duty      <= '0;
            step_cnt  <= '0;
            stall_cnt <= '0;
            oc_cnt    <= '0;
            ERR       <= 1'b0;
            RUNNING   <= 1'b0;
        end else begin
            state     <= state_d;
            duty      <= duty_d;
            step_cnt  <= step_cnt_d;
            stall_cnt <= stall_cnt_d;
            oc_cnt    <= oc_cnt_d;
            ERR       <= (state_d == ST_FAULT);
            RUNNING   <= (state_d == ST_RUN);
        end
    end

    pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD)
    ) u_pwm (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .duty      (duty),
        .force_off (pwm_off),
        .pwm       (PWM_OUT)
    );

endmodule

// File: doc/motor_channel_ctrl.md
Name: motor_channel_ctrl

Overview:
- Per-motor responder on the machine-control motor interface: consumes one MOT_ENA bit, drives the motor PWM and returns the matching MOT_ERR bit.
- Runs soft-start, stall watchdog and overcurrent debounce, and latches the fault until enable is withdrawn.
- One instance is built per motor channel (5 in the machine), sitting between the supervisor and the power stage.

Parameters:
- PWM_PERIOD, 100, PWM period in CLK cycles (>=2).
- DUTY_MAX, 80, full-run duty in counts; must be <= PWM_PERIOD.
- RAMP_STEP_CYC, 50, CLK cycles between +1 duty steps during ramp (>=1).
- STALL_CYC, 1000, maximum CLK cycles without ENC_TICK while in RUN.
- OC_DEBOUNCE, 4, consecutive OC_IN-high cycles needed to declare overcurrent (>=1).

Ports:
- CLK  input  1  system clock.
- RSTn  input  1  synchronous, active-low reset.
- ENA  input  1  motor enable from supervisor (one MOT_ENA bit); level-sensitive.
- OC_IN  input  1  overcurrent comparator; active high; already synchronised.
- ENC_TICK  input  1  one-cycle encoder pulse; already synchronised.
- PWM_OUT  output  1  gate drive to power stage.
- ERR  output  1  fault flag to supervisor (one MOT_ERR bit).
- RUNNING  output  1  high only in RUN state.

Behaviour:
- Reset (RSTn=0 at a CLK edge):
  - state=OFF, duty=0, all counters=0.
  - PWM_OUT=0, ERR=0, RUNNING=0.
  - Reset mid-ramp or mid-fault returns to OFF on the same edge.
- Duty register width: clog2(PWM_PERIOD+1).
- PWM counter: free-runs 0..PWM_PERIOD-1, wraps to 0.
- PWM_OUT is registered: PWM_OUT <= (pwm_cnt < duty) && state in {RAMP, RUN}. One-cycle latency from duty/state to pin.
- duty=0 gives constant low; duty=PWM_PERIOD gives constant high.
- States:
  - OFF: duty=0. Goes to RAMP when ENA=1 (checked every cycle).
  - RAMP: step counter counts to RAMP_STEP_CYC-1, then duty+1 and the counter clears. The step that makes duty==DUTY_MAX moves to RUN on the same edge. DUTY_MAX=0 goes straight from RAMP to RUN on the next edge.
  - RUN: duty holds DUTY_MAX. Stall counter clears on ENC_TICK, otherwise increments. Reaching STALL_CYC-1 without a tick goes to FAULT. The stall counter is cleared on every entry to RUN.
  - FAULT: duty=0, ERR=1. Exits to OFF only on a cycle where ENA=0. ERR drops on the same edge as the state change, so it is low in the first cycle of OFF. Holding ENA=1 keeps FAULT indefinitely, with no auto-restart.
- Overcurrent:
  - The debounce counter increments while OC_IN=1 and clears on OC_IN=0.
  - Reaching OC_DEBOUNCE in RAMP or RUN goes to FAULT.
  - The counter is cleared in OFF and in FAULT.
- ENA=0 in RAMP or RUN: go to OFF next edge; duty=0 immediately; ERR stays 0.
- Priority on the same edge, highest first: reset > fault condition (stall or OC) > ENA=0 > ramp step.
  - A fault coinciding with ENA drop still enters FAULT, so ERR is visible for at least one cycle before OFF.
- ERR, RUNNING: registered, decoded from state, never glitch.

Optional Feature:
- Macro: MOTOR_CHANNEL_SOFTSTOP_EN.
- Defined:
  - ENA=0 in RUN or RAMP enters state RAMP_DOWN.
  - In RAMP_DOWN, duty decrements by 1 every RAMP_STEP_CYC cycles. Reaching duty=0 goes to OFF.
  - ENA=1 during RAMP_DOWN returns to RAMP from the current duty.
  - OC is still monitored in RAMP_DOWN; stall is not.
  - RUNNING=0 in RAMP_DOWN.
- Undefined: there is no RAMP_DOWN state and stop is immediate as above.

Decomposition:
- Shared package motor_pkg:
  - state encodings OFF=0, RAMP=1, RUN=2, FAULT=3, RAMP_DOWN=4 (3-bit).
  - a clog2 helper function.
  - the default timing constants.
  - The supervisor and a future multi-channel wrapper use the same package.
- Sub-module pwm_gen (PWM_PERIOD parameter; inputs CLK, RSTn, duty, force_off; output pwm):
  - holds the free-running counter and the registered compare.
- The FSM, ramp, stall and OC counters stay in motor_channel_ctrl.

Test Plan:
- Bench parameters: PWM_PERIOD=10, DUTY_MAX=6, RAMP_STEP_CYC=2, STALL_CYC=20, OC_DEBOUNCE=3.
- Soft-start: ENA 0->1, ENC_TICK every 5 cycles.
  - duty steps 1..6, one step every 2 cycles; RUN after 12 cycles in RAMP.
  - RUNNING=1, then PWM_OUT high 6 of every 10 cycles; ERR stays 0.
- Stall: in RUN stop ENC_TICK.
  - FAULT after 19 tickless cycles; ERR=1, PWM_OUT=0 next cycle.
  - ENA held 1 keeps ERR=1; ENA->0 gives OFF and ERR=0.
- Overcurrent debounce: in RAMP pulse OC_IN high 2 cycles, low 1, then high 3.
  - The first burst is ignored.
  - FAULT on the 3rd consecutive high cycle.
- Simultaneous: ENA->0 on the same edge the OC count reaches 3.
  - ERR=1 for exactly one cycle, then OFF with ERR=0.
- Reset mid-operation: RSTn=0 for 1 cycle during RUN with PWM_OUT=1.
  - PWM_OUT, ERR and RUNNING are all 0 after that edge.
  - With ENA still 1, RAMP restarts from duty 0.
- MOTOR_CHANNEL_SOFTSTOP_EN: ENA->0 in RUN.
  - duty 6->0 in 12 cycles, then OFF.
  - ENA->1 at duty=3 gives RAMP resuming at 3.
